// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI/host RAM arbiter: SPI command codes, FSM states and owner encoding.
package spi_ram_pkg;

   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      RESP   = 2'b10
   } state_e;

   typedef enum logic {
      OWN_SPI  = 1'b0,
      OWN_HOST = 1'b1
   } owner_e;

   // Commands with bit 0 set touch the RAM; the others only load an address register.
   function automatic logic is_data_cmd(input cmd_e cmd);
      return cmd[0];
   endfunction

endpackage

// File: rtl/spi_ram_rr_arb.sv
// Two-way arbiter between the SPI command stream and the host port.
// Define ARB_FIXED_PRI_EN for fixed SPI priority; otherwise ties alternate round-robin.
module spi_ram_rr_arb
   import spi_ram_pkg::*;
(
   input  logic   req_spi,
   input  logic   req_host,
   input  owner_e last_grant,
   output owner_e winner
);

`ifdef ARB_FIXED_PRI_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant;

   assign winner = (req_spi || !req_host) ? OWN_SPI : OWN_HOST;
`else
   // On a tie the side that was not served last goes next.
   always_comb begin
      winner = OWN_SPI;
      if (req_spi && req_host) begin
         winner = (last_grant == OWN_HOST) ? OWN_SPI : OWN_HOST;
      end else if (req_host) begin
         winner = OWN_HOST;
      end
   end
`endif

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares one single-port RAM between SPI command frames and a host req/gnt port.
// Arbitration policy is selected by ARB_FIXED_PRI_EN (see spi_ram_rr_arb).
module spi_ram_arbiter
   import spi_ram_pkg::*;
#(
   parameter int ADDR_SIZE = 8,
   parameter int DATA_W    = 8,
   parameter int MEM_DEPTH = 256
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [9:0]           rx_data,
   input  logic                 rx_valid,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 host_req,
   input  logic                 host_we,
   input  logic [ADDR_SIZE-1:0] host_addr,
   input  logic [DATA_W-1:0]    host_wdata,
   output logic                 host_gnt,
   output logic                 host_rvalid,
   output logic [DATA_W-1:0]    host_rdata,
   output logic                 ram_en,
   output logic                 ram_we,
   output logic [ADDR_SIZE-1:0] ram_addr,
   output logic [DATA_W-1:0]    ram_wdata,
   input  logic [DATA_W-1:0]    ram_rdata,
   output logic                 spi_ovf
);

   logic [31:0] unused_depth;
   assign unused_depth = 32'(MEM_DEPTH);

   state_e                state_q;
   owner_e                owner_q;
   owner_e                last_grant_q;
   owner_e                winner;
   logic [ADDR_SIZE-1:0]  wr_addr_q;
   logic [ADDR_SIZE-1:0]  rd_addr_q;
   logic                  spi_pend_q;
   logic                  spi_op_wr_q;
   logic [DATA_W-1:0]     spi_data_q;
   logic [7:0]            tx_data_q;
   logic                  tx_valid_q;
   logic                  host_gnt_q;
   logic                  host_rvalid_q;
   logic [DATA_W-1:0]     host_rdata_q;
   logic                  ram_en_q;
   logic                  ram_we_q;
   logic [ADDR_SIZE-1:0]  ram_addr_q;
   logic [DATA_W-1:0]     ram_wdata_q;
   logic                  spi_ovf_q;
   cmd_e                  cmd;

   assign cmd = cmd_e'(rx_data[9:8]);

   spi_ram_rr_arb u_arb (
      .req_spi    (spi_pend_q),
      .req_host   (host_req),
      .last_grant (last_grant_q),
      .winner     (winner)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         owner_q       <= OWN_SPI;
         last_grant_q  <= OWN_HOST;
         wr_addr_q     <= '0;
         rd_addr_q     <= '0;
         spi_pend_q    <= 1'b0;
         spi_op_wr_q   <= 1'b0;
         spi_data_q    <= '0;
         tx_data_q     <= '0;
         tx_valid_q    <= 1'b0;
         host_gnt_q    <= 1'b0;
         host_rvalid_q <= 1'b0;
         host_rdata_q  <= '0;
         ram_en_q      <= 1'b0;
         ram_we_q      <= 1'b0;
         ram_addr_q    <= '0;
         ram_wdata_q   <= '0;
         spi_ovf_q     <= 1'b0;
      end else begin
         tx_valid_q    <= 1'b0;
         host_rvalid_q <= 1'b0;
         host_gnt_q    <= 1'b0;
         ram_en_q      <= 1'b0;
         ram_we_q      <= 1'b0;

         // A second data command while one is still pending is dropped and flagged.
         if (rx_valid) begin
            case (cmd)
               CMD_WR_ADDR: wr_addr_q <= rx_data[7:0];
               CMD_RD_ADDR: rd_addr_q <= rx_data[7:0];
               default: begin
                  if (spi_pend_q) begin
                     spi_ovf_q <= 1'b1;
                  end else if (is_data_cmd(cmd)) begin
                     spi_pend_q  <= 1'b1;
                     spi_op_wr_q <= (cmd == CMD_WR_DATA);
                     spi_data_q  <= rx_data[7:0];
                  end
               end
            endcase
         end

         case (state_q)
            IDLE: begin
               if (spi_pend_q || host_req) begin
                  owner_q  <= winner;
                  ram_en_q <= 1'b1;
                  state_q  <= ACCESS;
                  if (winner == OWN_SPI) begin
                     ram_we_q    <= spi_op_wr_q;
                     ram_addr_q  <= spi_op_wr_q ? wr_addr_q : rd_addr_q;
                     ram_wdata_q <= spi_data_q;
                  end else begin
                     ram_we_q    <= host_we;
                     ram_addr_q  <= host_addr;
                     ram_wdata_q <= host_wdata;
                     host_gnt_q  <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               last_grant_q <= owner_q;
               if (owner_q == OWN_SPI) begin
                  spi_pend_q <= 1'b0;
               end
               state_q <= ram_we_q ? IDLE : RESP;
            end
            RESP: begin
               if (owner_q == OWN_SPI) begin
                  tx_data_q  <= ram_rdata;
                  tx_valid_q <= 1'b1;
               end else begin
                  host_rdata_q  <= ram_rdata;
                  host_rvalid_q <= 1'b1;
               end
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx_data     = tx_data_q;
   assign tx_valid    = tx_valid_q;
   assign host_gnt    = host_gnt_q;
   assign host_rvalid = host_rvalid_q;
   assign host_rdata  = host_rdata_q;
   assign ram_en      = ram_en_q;
   assign ram_we      = ram_we_q;
   assign ram_addr    = ram_addr_q;
   assign ram_wdata   = ram_wdata_q;
   assign spi_ovf     = spi_ovf_q;

endmodule
